// File: rtl/mdf_pkg.sv
// mdf_pkg: shared definitions for the mdf_mul_unit pipelined multiplier.
//   mdf_op_e    - operation encodings carried on in_op
//   mdf_clog2() - ceiling log2, used to size the adder tree and latency
package mdf_pkg;

  typedef enum logic [1:0] {
    MDF_OP_MUL    = 2'd0,  // low half, sign-agnostic
    MDF_OP_MULH   = 2'd1,  // signed x signed, high half
    MDF_OP_MULHSU = 2'd2,  // signed x unsigned, high half
    MDF_OP_MULHU  = 2'd3   // unsigned x unsigned, high half
  } mdf_op_e;

  function automatic int unsigned mdf_clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdf_mul_unit_if.sv
// mdf_mul_unit_if: issue/result handshake bundle for mdf_mul_unit.
//   in_valid/in_ready  - operation offer / acceptance
//   in_op, in_a, in_b  - operation select and operands
//   in_tag             - opaque tag returned with the result
//   out_valid/out_ready- result offer / consumption
//   out_result,out_tag - selected product half and its tag
// Modports: master (issuer and result consumer), slave (the multiplier).
interface mdf_mul_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );

endinterface

// File: rtl/mdf_mul_stage.sv
// mdf_mul_stage: one registered level of the partial-product adder tree.
//   clk, RST        - clock, synchronous active-high reset
//   flush_i         - drop the held operation (valid cleared)
//   stall_i         - hold every register
//   valid_i/_o      - operation valid in / out
//   op_i/_o         - operation select carried alongside
//   tag_i/_o        - tag carried alongside
//   neg_i/_o        - final-product sign carried alongside
//   data_i          - N summands; data_o - N/2 registered pairwise sums
module mdf_mul_stage
  import mdf_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned DW    = 64,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     flush_i,
  input  logic                     stall_i,
  input  logic                     valid_i,
  input  mdf_op_e                  op_i,
  input  logic [TAG_W-1:0]         tag_i,
  input  logic                     neg_i,
  input  logic [N-1:0][DW-1:0]     data_i,
  output logic                     valid_o,
  output mdf_op_e                  op_o,
  output logic [TAG_W-1:0]         tag_o,
  output logic                     neg_o,
  output logic [N/2-1:0][DW-1:0]   data_o
);

  localparam int unsigned M = N / 2;

  logic [M-1:0][DW-1:0] sum_d;
  logic [M-1:0][DW-1:0] data_q;
  logic                 valid_q;
  mdf_op_e              op_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 neg_q;

  always_comb begin
    sum_d = '0;
    for (int j = 0; j < int'(M); j++) begin
      sum_d[j] = data_i[2*j] + data_i[2*j+1];
    end
  end

  // Payload only loads with a valid operation so idle cycles do not toggle the tree.
  always_ff @(posedge clk) begin
    if (RST) begin
      valid_q <= 1'b0;
      op_q    <= MDF_OP_MUL;
      tag_q   <= '0;
      neg_q   <= 1'b0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        op_q   <= op_i;
        tag_q  <= tag_i;
        neg_q  <= neg_i;
        data_q <= sum_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign op_o    = op_q;
  assign tag_o   = tag_q;
  assign neg_o   = neg_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mdf_mul_unit.sv
// mdf_mul_unit: fixed-latency pipelined integer multiplier (LAT = clog2(WIDTH)+2).
//   clk    - clock
//   RST    - synchronous active-high reset
//   flush  - squash every operation in flight, refuse this cycle's offer
//   busy   - some pipeline stage holds a valid operation
//   bus    - mdf_mul_unit_if.slave issue/result handshake
// Stage 1 registers WIDTH partial products of operand magnitudes, stages
// 2..LAT-1 are mdf_mul_stage adder-tree levels, stage LAT applies the sign and
// selects the result half.
// Build option: define MDF_MUL_HIGH_EN to enable MULH/MULHSU/MULHU; without it
// in_op is ignored and every operation is an unsigned low-half MUL.
module mdf_mul_unit
  import mdf_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          flush,
  output logic          busy,
  mdf_mul_unit_if.slave bus
);

  localparam int unsigned LAT    = mdf_clog2(WIDTH) + 2;
  localparam int unsigned LEVELS = LAT - 2;
`ifdef MDF_MUL_HIGH_EN
  localparam int unsigned PW = 2 * WIDTH;
`else
  // Only the low half is ever returned, so the tree is truncated to WIDTH bits.
  localparam int unsigned PW = WIDTH;
`endif
  // All tree levels packed back to back: level k starts at 2*WIDTH - 2*(WIDTH>>k).
  localparam int unsigned NODES = 2 * WIDTH - 1;

  logic stall;
  logic in_ready;
  logic accept;

  logic [NODES-1:0][PW-1:0] node;
  logic [LEVELS:0]          lvl_valid;
  mdf_op_e                  lvl_op  [LEVELS+1];
  logic [TAG_W-1:0]         lvl_tag [LEVELS+1];
  logic [LEVELS:0]          lvl_neg;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  assign stall    = out_valid_q && !bus.out_ready;
  assign in_ready = !stall && !flush && !RST;
  assign accept   = bus.in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: operand magnitudes and partial products
  // ---------------------------------------------------------------------------
  mdf_op_e          op_in;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg_d;

`ifdef MDF_MUL_HIGH_EN
  logic a_neg;
  logic b_neg;

  always_comb begin
    op_in = mdf_op_e'(bus.in_op);
    a_neg = (op_in == MDF_OP_MULH || op_in == MDF_OP_MULHSU) && bus.in_a[WIDTH-1];
    b_neg = (op_in == MDF_OP_MULH) && bus.in_b[WIDTH-1];
    // Magnitude of the most-negative value wraps to itself, which is correct unsigned.
    a_mag = a_neg ? -bus.in_a : bus.in_a;
    b_mag = b_neg ? -bus.in_b : bus.in_b;
    neg_d = a_neg ^ b_neg;
  end
`else
  always_comb begin
    op_in = MDF_OP_MUL;
    a_mag = bus.in_a;
    b_mag = bus.in_b;
    neg_d = 1'b0;
  end
`endif

  logic [WIDTH-1:0][PW-1:0] pp_d;
  logic [WIDTH-1:0][PW-1:0] pp_q;
  logic                     s1_valid_q;
  mdf_op_e                  s1_op_q;
  logic [TAG_W-1:0]         s1_tag_q;
  logic                     s1_neg_q;

  always_comb begin
    pp_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pp_d[i] = b_mag[i] ? (PW'(a_mag) << i) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= MDF_OP_MUL;
      s1_tag_q   <= '0;
      s1_neg_q   <= 1'b0;
      pp_q       <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_op_q  <= op_in;
        s1_tag_q <= bus.in_tag;
        s1_neg_q <= neg_d;
        pp_q     <= pp_d;
      end
    end
  end

  assign node[WIDTH-1:0] = pp_q;
  assign lvl_valid[0]    = s1_valid_q;
  assign lvl_op[0]       = s1_op_q;
  assign lvl_tag[0]      = s1_tag_q;
  assign lvl_neg[0]      = s1_neg_q;

  // ---------------------------------------------------------------------------
  // Stages 2..LAT-1: adder tree, one level per stage
  // ---------------------------------------------------------------------------
  for (genvar k = 1; k <= int'(LEVELS); k++) begin : g_lvl
    localparam int unsigned NIN   = WIDTH >> (k - 1);
    localparam int unsigned OFF_I = 2 * WIDTH - 2 * NIN;
    localparam int unsigned OFF_O = 2 * WIDTH - NIN;

    mdf_mul_stage #(
      .N     (NIN),
      .DW    (PW),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk     (clk),
      .RST     (RST),
      .flush_i (flush),
      .stall_i (stall),
      .valid_i (lvl_valid[k-1]),
      .op_i    (lvl_op[k-1]),
      .tag_i   (lvl_tag[k-1]),
      .neg_i   (lvl_neg[k-1]),
      .data_i  (node[OFF_I +: NIN]),
      .valid_o (lvl_valid[k]),
      .op_o    (lvl_op[k]),
      .tag_o   (lvl_tag[k]),
      .neg_o   (lvl_neg[k]),
      .data_o  (node[OFF_O +: NIN/2])
    );
  end

  // ---------------------------------------------------------------------------
  // Stage LAT: sign fix-up, half select, result register
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    sum_f;
  logic [WIDTH-1:0] res_d;

  assign sum_f = node[NODES-1];

`ifdef MDF_MUL_HIGH_EN
  logic [PW-1:0] prod_fix;

  always_comb begin
    prod_fix = lvl_neg[LEVELS] ? -sum_f : sum_f;
    res_d    = (lvl_op[LEVELS] == MDF_OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[PW-1:WIDTH];
  end
`else
  assign res_d = sum_f;

  // Op and sign travel the pipeline but are constant in this build.
  logic unused_hi;
  assign unused_hi = ^{bus.in_op, lvl_op[LEVELS], lvl_neg[LEVELS]};
`endif

  // Result and tag only load with a new valid so they stay put while out_valid is low.
  always_ff @(posedge clk) begin
    if (RST) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= lvl_valid[LEVELS];
      if (lvl_valid[LEVELS]) begin
        out_result_q <= res_d;
        out_tag_q    <= lvl_tag[LEVELS];
      end
    end
  end

  assign busy           = (|lvl_valid) | out_valid_q;
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;

endmodule

// File: tb/tb_mdf_mul_unit.sv
// tb_mdf_mul_unit: scoreboard bench for mdf_mul_unit at WIDTH=32, TAG_W=4.
// Stimulus pushes hand-computed {result, tag} expectations; a negedge monitor
// pops and compares on every output transfer.
module tb_mdf_mul_unit;
  import mdf_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAG_W = 4;
  localparam int          LAT   = 7;
`ifdef MDF_MUL_HIGH_EN
  localparam bit HI = 1'b1;
`else
  localparam bit HI = 1'b0;
`endif

  logic clk = 1'b0;
  logic RST;
  logic flush;
  logic busy;

  mdf_mul_unit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  mdf_mul_unit #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk   (clk),
    .RST   (RST),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!RST && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got tag %0d result 0x%0h, expected no output",
                 bus.out_tag, bus.out_result);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("result_tag%0d", mon_e.tag), {28'd0, bus.out_tag, bus.out_result},
              {28'd0, mon_e.tag, mon_e.res});
      end
    end
  end

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_op    = 2'd0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_tag   = '0;
  endtask

  // Called at posedge+1; returns at the following posedge+1 with in_valid still set.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] exp_res);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    @(negedge clk);
    check($sformatf("in_ready_tag%0d", tag), bus.in_ready, 1);
    if (bus.in_ready) begin
      e.res = exp_res;
      e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int exp_k);
    int k;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        k = i;
        break;
      end
    end
    check(name, k, exp_k);
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (sb.size() != 0 && c < 60) begin
      @(negedge clk);
      c++;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    RST           = 1'b1;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    idle();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    RST = 1'b0;

    // Single MUL, latency
    @(posedge clk);
    #1;
    issue(MDF_OP_MUL, 32'd7, 32'd6, 4'd3, 32'd42);
    idle();
    wait_valid("latency_mul_7x6", LAT);
    drain("drain_basic");

    // All-ones and most-negative operands, back to back
    @(posedge clk);
    #1;
    issue(MDF_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, HI ? 32'h0000_0000 : 32'h1);
    issue(MDF_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, HI ? 32'hFFFF_FFFF : 32'h1);
    issue(MDF_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, HI ? 32'hFFFF_FFFE : 32'h1);
    issue(MDF_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 32'h0000_0001);
    issue(MDF_OP_MULH,   32'h8000_0000, 32'h8000_0000, 4'd5, HI ? 32'h4000_0000 : 32'h0);
    issue(MDF_OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 4'd6, HI ? 32'hC000_0000 : 32'h0);
    issue(MDF_OP_MULHU,  32'h8000_0000, 32'h8000_0000, 4'd7, HI ? 32'h4000_0000 : 32'h0);
    issue(MDF_OP_MUL,    32'h0000_FFFF, 32'h0000_FFFF, 4'd8, 32'hFFFE_0001);
    idle();
    drain("drain_vectors");

    // Back-pressure: 7 ops, first result held for 3 cycles
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      issue(MDF_OP_MUL, 32'(i + 1), 32'(i + 3), 4'(i), 32'((i + 1) * (i + 3)));
    end
    bus.out_ready = 1'b0;
    check("stall_first_valid", bus.out_valid, 1);
    // Offer during stall must not be taken.
    bus.in_valid = 1'b1;
    bus.in_a     = 32'd99;
    bus.in_b     = 32'd99;
    bus.in_tag   = 4'd15;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall_in_ready_c%0d", c), bus.in_ready, 0);
      check($sformatf("stall_out_valid_c%0d", c), bus.out_valid, 1);
      check($sformatf("stall_hold_c%0d", c), {bus.out_tag, bus.out_result}, {4'd0, 32'd3});
      check($sformatf("stall_busy_c%0d", c), busy, 1);
      @(posedge clk);
      #1;
    end
    idle();
    bus.out_ready = 1'b1;
    drain("drain_stall");

    // Flush with 3 in flight and a same-cycle offer
    @(posedge clk);
    #1;
    issue(MDF_OP_MUL, 32'd2, 32'd2, 4'd1, 32'd4);
    issue(MDF_OP_MUL, 32'd3, 32'd3, 4'd2, 32'd9);
    issue(MDF_OP_MUL, 32'd4, 32'd4, 4'd3, 32'd16);
    bus.in_a   = 32'd5;
    bus.in_b   = 32'd5;
    bus.in_tag = 4'd9;
    flush      = 1'b1;
    @(negedge clk);
    check("flush_in_ready", bus.in_ready, 0);
    sb.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle();
    @(negedge clk);
    check("flush_busy", busy, 0);
    expect_quiet("flush_no_output", LAT);

    // Reset with 4 in flight, consumer stalled
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    issue(MDF_OP_MUL, 32'd10, 32'd10, 4'd1, 32'd100);
    issue(MDF_OP_MUL, 32'd11, 32'd11, 4'd2, 32'd121);
    issue(MDF_OP_MUL, 32'd12, 32'd12, 4'd3, 32'd144);
    issue(MDF_OP_MUL, 32'd13, 32'd13, 4'd4, 32'd169);
    bus.in_a = 32'd7;
    bus.in_b = 32'd7;
    RST      = 1'b1;
    @(negedge clk);
    check("rst2_in_ready", bus.in_ready, 0);
    sb.delete();
    @(posedge clk);
    #1;
    RST = 1'b0;
    idle();
    @(negedge clk);
    check("rst2_out_valid", bus.out_valid, 0);
    check("rst2_busy", busy, 0);
    check("rst2_out_result", bus.out_result, 0);
    check("rst2_out_tag", bus.out_tag, 0);
    bus.out_ready = 1'b1;
    expect_quiet("rst2_no_stale", 10);
    @(posedge clk);
    #1;
    issue(MDF_OP_MUL,  32'h8000_0000, 32'd2, 4'd1, 32'h0000_0000);
    issue(MDF_OP_MULH, 32'h8000_0000, 32'd2, 4'd2, HI ? 32'hFFFF_FFFF : 32'h0);
    idle();
    drain("drain_post_rst");

    // MULHU 0x10000 squared, latency
    @(posedge clk);
    #1;
    issue(MDF_OP_MULHU, 32'h0001_0000, 32'h0001_0000, 4'd5, HI ? 32'h1 : 32'h0);
    idle();
    wait_valid("latency_mulhu", LAT);
    drain("drain_mulhu");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdf_mul_unit.md
MDF_MUL_UNIT -- requirements
Module: mdf_mul_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; power of two, 4..64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the opaque tag carried alongside each operation.
REQ-003 SHALL have local constant LAT = clog2(WIDTH)+2 (7 at WIDTH=32), the fixed issue-to-result latency.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  operation offered.
REQ-007 in_ready  out  1  unit accepts the offered operation this cycle.
REQ-008 in_op  in  2  0=MUL (low half), 1=MULH (s x s, high), 2=MULHSU (s x u, high), 3=MULHU (u x u, high).
REQ-009 in_a, in_b  in  WIDTH  operands.
REQ-010 in_tag  in  TAG_W  tag returned with the result.
REQ-011 flush  in  1  squash every operation in flight.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer takes the result.
REQ-014 out_result  out  WIDTH  selected half of the 2*WIDTH product.
REQ-015 out_tag  out  TAG_W  tag of the presented result.
REQ-016 busy  out  1  any pipeline stage holds a valid operation.

Function
REQ-017 Accept occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-018 stall = out_valid && !out_ready; in_ready SHALL equal !stall && !flush.
REQ-019 While stall, every stage (data, op, tag, valid) SHALL hold; no operation is lost, duplicated or reordered.
REQ-020 Without stall, an operation accepted in cycle N SHALL appear with out_valid=1 in cycle N+LAT.
REQ-021 Throughput SHALL be one operation per cycle; up to LAT operations in flight.
REQ-022 Stage 1 registers WIDTH partial products (operand magnitudes per in_op signedness) plus result sign; stages 2..LAT-1 form a pairwise adder tree of 2*WIDTH-bit sums; stage LAT applies sign fix-up and half select.
REQ-023 Result = low WIDTH bits of a*b for MUL; high WIDTH bits of the exact 2*WIDTH-bit product for MULH/MULHSU/MULHU; signed/unsigned interpretation per REQ-008; no overflow flag.
REQ-024 Most-negative operand (0x80000000 at WIDTH=32) SHALL produce the exact product.
REQ-025 flush SHALL clear every stage valid bit on the next edge, override stall, and drop a same-cycle in_valid (no accept).
REQ-026 out_result and out_tag SHALL be don't-care-stable: they hold their last value when out_valid=0.
REQ-027 busy SHALL be the OR of all stage valid bits, registered state only.

Reset
REQ-028 While RST=1 on an edge: all valid bits 0, out_valid=0, busy=0, out_result=0, out_tag=0, all pipeline data 0.
REQ-029 RST SHALL take priority over flush, stall and accept; an in_valid during RST is dropped; in_ready=0 while RST=1.
REQ-030 Reset mid-operation SHALL discard all in-flight operations with no result emitted.

Configuration
REQ-031 Macro MDF_MUL_HIGH_EN defined: all four in_op encodings operate per REQ-023.
REQ-032 Macro MDF_MUL_HIGH_EN undefined: in_op is ignored, every operation behaves as MUL (unsigned low half), sign logic and upper product bits are omitted; LAT and handshake unchanged.

Structure
REQ-033 Package mdf_pkg SHALL hold the op encodings (MDF_OP_MUL, MDF_OP_MULH, MDF_OP_MULHSU, MDF_OP_MULHU) and the clog2 constant function.
REQ-034 One sub-module mdf_mul_stage SHALL implement a generic registered adder-tree level (N inputs -> N/2 sums, valid/op/tag/sign carried, hold on stall, clear on flush/RST), instanced per tree level.

Verification
REQ-035 WIDTH=32, MUL 7 x 6 tag 3, out_ready=1 -> out_valid in cycle N+7, out_result=42, out_tag=3.
REQ-036 a=b=0xFFFFFFFF: MULH->0x00000000, MULHSU->0xFFFFFFFF, MULHU->0xFFFFFFFE, MUL->0x00000001.
REQ-037 7 back-to-back ops tags 0..6, out_ready=0 for 3 cycles at first result -> in_ready=0, outputs held, all 7 emerge in tag order, none lost.
REQ-038 3 ops in flight, flush=1 with in_valid=1 same cycle -> next cycle busy=0, no out_valid for following 7 cycles.
REQ-039 RST pulsed with 4 ops in flight and out_ready=0 -> all outputs 0 next cycle, no stale result afterward; new MUL 0x80000000 x 2 -> 0x00000000, MULH -> 0xFFFFFFFF.
REQ-040 Build without MDF_MUL_HIGH_EN, MULHU 0x10000 x 0x10000 -> out_result=0x00000000 (low half), latency 7.
